// File: rtl/vga_layer_compositor.sv
// VGA timing generator plus an N-layer priority compositor. Syncs and video_on are
// delayed to match the layer pipeline, and layers can blink on a frame-count basis.
module vga_layer_compositor #(
  parameter int COLOR_W      = 4,
  parameter int N_LAYERS     = 3,
  parameter int TICK_DIV     = 4,
  parameter int H_VISIBLE    = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int LAYER_LAT    = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [N_LAYERS-1:0]             layer_on_i,
  input  logic [N_LAYERS*3*COLOR_W-1:0]   layer_rgb_i,
  input  logic [N_LAYERS-1:0]             layer_blink_en_i,
  input  logic [3*COLOR_W-1:0]            bg_rgb_i,
  output logic [9:0]                      pixel_x_o,
  output logic [9:0]                      pixel_y_o,
  output logic                            pixel_tick_o,
  output logic                            video_on_o,
  output logic                            frame_start_o,
  output logic                            blink_phase_o,
  output logic                            hsync_o,
  output logic                            vsync_o,
  output logic [3*COLOR_W-1:0]            rgb_o
);
  localparam int RGB_W   = 3*COLOR_W;
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0]    div_q, div_d;
  logic [9:0]          h_q, h_d, v_q, v_d;
  logic [FC_W-1:0]     fcnt_q, fcnt_d;
  logic                blink_q, blink_d;
  logic                hsync_q, vsync_q;
  logic [RGB_W-1:0]    rgb_q, rgb_d, win_rgb;
  logic [N_LAYERS-1:0] eff_on;
  logic                tick, frame_start;
  logic                hs_raw, vs_raw, von_raw;
  logic [2:0]          raw, aligned;   // {hsync, vsync, video_on}

  assign tick        = (div_q == DIV_LAST);
  assign frame_start = tick && (h_q == H_LAST) && (v_q == V_LAST);
  assign hs_raw      = !((h_q >= HS_BEG) && (h_q < HS_END));
  assign vs_raw      = !((v_q >= VS_BEG) && (v_q < VS_END));
  assign von_raw     = (h_q < H_VIS) && (v_q < V_VIS);
  assign raw         = {hs_raw, vs_raw, von_raw};

  always_comb begin
    div_d  = tick ? '0 : div_q + 1'b1;
    h_d    = h_q;
    v_d    = v_q;
    fcnt_d = fcnt_q;
    blink_d = blink_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    // Phase flips on the wrap tick, so it is stable across the whole next frame.
    if (frame_start) begin
      if (fcnt_q == FC_LAST) begin
        fcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  if (LAYER_LAT == 0) begin : g_no_dly
    assign aligned = raw;
  end else begin : g_dly
    logic [2:0] dly_q [LAYER_LAT];
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < LAYER_LAT; i++) dly_q[i] <= 3'b110;
      end else if (tick) begin
        dly_q[0] <= raw;
        for (int i = 1; i < LAYER_LAT; i++) dly_q[i] <= dly_q[i-1];
      end
    end
    assign aligned = dly_q[LAYER_LAT-1];
  end

  // Scan from lowest priority upward so the lowest active index wins.
  always_comb begin
    eff_on  = layer_on_i & ~(layer_blink_en_i & {N_LAYERS{blink_q}});
    win_rgb = bg_rgb_i;
    for (int i = N_LAYERS-1; i >= 0; i--) begin
      if (eff_on[i]) win_rgb = layer_rgb_i[i*RGB_W +: RGB_W];
    end
    rgb_d = aligned[0] ? win_rgb : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      fcnt_q  <= '0;
      blink_q <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= '0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      fcnt_q  <= fcnt_d;
      blink_q <= blink_d;
      if (tick) begin
        hsync_q <= aligned[2];
        vsync_q <= aligned[1];
        rgb_q   <= rgb_d;
      end
    end
  end

  assign pixel_x_o     = h_q;
  assign pixel_y_o     = v_q;
  assign pixel_tick_o  = tick;
  assign video_on_o    = von_raw;
  assign frame_start_o = frame_start;
  assign blink_phase_o = blink_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign rgb_o         = rgb_q;
endmodule

// File: tb/tb_vga_layer_compositor.sv
// Directed bench for vga_layer_compositor on a shrunken raster (54x17, TICK_DIV=4,
// LAYER_LAT=2, BLINK_FRAMES=2) so whole frames fit in a short run.
module tb_vga_layer_compositor;
  localparam int CW = 4, NL = 3;
  // H: 40+4+6+4 = 54 ; V: 10+2+2+3 = 17 ; hsync low raw h=44..49 ; vsync low raw v=12..13
  // Output pipeline = LAYER_LAT+1 = 3 ticks, so output hsync falls when pixel_x=47.

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NL-1:0]   layer_on = '0, layer_blink_en = '0;
  logic [NL*12-1:0] layer_rgb = {12'h00F, 12'h0F0, 12'hF00};
  logic [11:0]     bg_rgb = 12'h000;
  logic [9:0]      pixel_x, pixel_y;
  logic            pixel_tick, video_on, frame_start, blink_phase, hsync, vsync;
  logic [11:0]     rgb;
  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  vga_layer_compositor #(
    .COLOR_W(CW), .N_LAYERS(NL), .TICK_DIV(4),
    .H_VISIBLE(40), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_VISIBLE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .LAYER_LAT(2), .BLINK_FRAMES(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .layer_on_i(layer_on), .layer_rgb_i(layer_rgb), .layer_blink_en_i(layer_blink_en),
    .bg_rgb_i(bg_rgb),
    .pixel_x_o(pixel_x), .pixel_y_o(pixel_y), .pixel_tick_o(pixel_tick),
    .video_on_o(video_on), .frame_start_o(frame_start), .blink_phase_o(blink_phase),
    .hsync_o(hsync), .vsync_o(vsync), .rgb_o(rgb)
  );

  // Returns at the first negedge after the counters step onto (x,y).
  task automatic wait_xy(input logic [9:0] x, input logic [9:0] y);
    logic [9:0] px, py;
    bit hit;
    px = pixel_x; py = pixel_y; hit = 0;
    for (int c = 0; c < 9000 && !hit; c++) begin
      @(negedge clk);
      if (pixel_x == x && pixel_y == y && !(px == x && py == y)) hit = 1;
      px = pixel_x; py = pixel_y;
    end
    if (!hit) begin
      n_total++;
      $display("FAIL wait_xy timeout: at (%0d,%0d), required (%0d,%0d)", pixel_x, pixel_y, x, y);
    end
  endtask

  task automatic test_reset();
    int first;
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    n_total++; if (hsync !== 1'b1) $display("FAIL rst_hsync: got %b exp 1", hsync); else n_pass++;
    n_total++; if (vsync !== 1'b1) $display("FAIL rst_vsync: got %b exp 1", vsync); else n_pass++;
    n_total++; if (rgb !== 12'h000) $display("FAIL rst_rgb: got %h exp 000", rgb); else n_pass++;
    n_total++; if (pixel_tick !== 1'b0) $display("FAIL rst_tick: got %b exp 0", pixel_tick); else n_pass++;
    n_total++; if (pixel_x !== 10'd0) $display("FAIL rst_px: got %0d exp 0", pixel_x); else n_pass++;
    rst_n = 1'b1;
    first = -1;
    // c counts clocks after release; c=0 is the release clock, so c=3 is clock 4.
    for (int c = 0; c <= 8; c++) begin
      if (pixel_tick === 1'b1 && first < 0) first = c;
      if (c == 7) begin
        n_total++; if (pixel_x !== 10'd1) $display("FAIL px_c7: got %0d exp 1", pixel_x); else n_pass++;
      end
      if (c == 8) begin
        n_total++; if (pixel_x !== 10'd2) $display("FAIL px_c8: got %0d exp 2", pixel_x); else n_pass++;
      end
      if (c < 8) @(negedge clk);
    end
    n_total++; if (first != 3) $display("FAIL first_tick: got clock idx %0d exp 3", first); else n_pass++;
  endtask

  task automatic test_sync_timing();
    logic prev;
    int lc, per, c;
    bit found;
    found = 0; prev = hsync;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (prev && !hsync) found = 1;
      prev = hsync;
    end
    n_total++; if (!found || pixel_x !== 10'd47) $display("FAIL hs_start: found %0d px %0d exp 47", found, pixel_x); else n_pass++;
    lc = 0;
    while (hsync === 1'b0 && lc < 1000) begin lc++; @(negedge clk); end
    per = lc;
    while (hsync === 1'b1 && per < 2000) begin per++; @(negedge clk); end
    n_total++; if (lc != 24) $display("FAIL hs_width: got %0d clocks exp 24", lc); else n_pass++;
    n_total++; if (per != 216) $display("FAIL line_period: got %0d clocks exp 216", per); else n_pass++;

    found = 0; prev = vsync;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(negedge clk);
      if (prev && !vsync) found = 1;
      prev = vsync;
    end
    n_total++; if (!found || pixel_x !== 10'd3 || pixel_y !== 10'd12)
      $display("FAIL vs_start: found %0d at (%0d,%0d) exp (3,12)", found, pixel_x, pixel_y); else n_pass++;
    lc = 0;
    while (vsync === 1'b0 && lc < 2000) begin lc++; @(negedge clk); end
    n_total++; if (lc != 432) $display("FAIL vs_width: got %0d clocks exp 432", lc); else n_pass++;

    c = 0;
    while (frame_start !== 1'b1 && c < 5000) begin c++; @(negedge clk); end
    n_total++; if (frame_start !== 1'b1 || pixel_x !== 10'd53 || pixel_y !== 10'd16)
      $display("FAIL fs_pos: fs %b at (%0d,%0d) exp 1 at (53,16)", frame_start, pixel_x, pixel_y); else n_pass++;
    @(negedge clk);
    n_total++; if (frame_start !== 1'b0 || pixel_x !== 10'd0 || pixel_y !== 10'd0)
      $display("FAIL fs_wrap: fs %b at (%0d,%0d) exp 0 at (0,0)", frame_start, pixel_x, pixel_y); else n_pass++;
    c = 1;
    while (frame_start !== 1'b1 && c < 5000) begin c++; @(negedge clk); end
    n_total++; if (c != 3672) $display("FAIL frame_period: got %0d clocks exp 3672", c); else n_pass++;
  endtask

  task automatic test_priority();
    logic [2:0]  pat [4] = '{3'b111, 3'b110, 3'b100, 3'b000};
    logic [11:0] exp [4] = '{12'hF00, 12'h0F0, 12'h00F, 12'h123};
    bg_rgb = 12'h123;
    for (int k = 0; k < 4; k++) begin
      wait_xy(10'd0, 10'(k + 1));
      layer_on = pat[k];
      wait_xy(10'd13, 10'(k + 1));
      n_total++; if (rgb !== exp[k]) $display("FAIL prio_%b: got %h exp %h", pat[k], rgb, exp[k]); else n_pass++;
    end
    wait_xy(10'd0, 10'd5);
    layer_on = 3'b111;
    wait_xy(10'd42, 10'd5);
    n_total++; if (rgb !== 12'hF00) $display("FAIL last_visible_x: got %h exp F00", rgb); else n_pass++;
    wait_xy(10'd43, 10'd5);
    n_total++; if (rgb !== 12'h000) $display("FAIL first_hblank_x: got %h exp 000", rgb); else n_pass++;
    wait_xy(10'd53, 10'd6);
    n_total++; if (rgb !== 12'h000) $display("FAIL hblank_px50: got %h exp 000", rgb); else n_pass++;
    wait_xy(10'd13, 10'd11);
    n_total++; if (rgb !== 12'h000) $display("FAIL vblank_row11: got %h exp 000", rgb); else n_pass++;
  endtask

  task automatic test_latency();
    layer_on = 3'b000;
    bg_rgb = 12'h123;
    wait_xy(10'd12, 10'd7);
    n_total++; if (rgb !== 12'h123) $display("FAIL lat_before: got %h exp 123", rgb); else n_pass++;
    layer_on = 3'b001;   // data for pixel 10, presented LAYER_LAT ticks later
    wait_xy(10'd13, 10'd7);
    layer_on = 3'b000;
    n_total++; if (rgb !== 12'hF00) $display("FAIL lat_hit: got %h exp F00", rgb); else n_pass++;
    wait_xy(10'd14, 10'd7);
    n_total++; if (rgb !== 12'h123) $display("FAIL lat_after: got %h exp 123", rgb); else n_pass++;
    wait_xy(10'd39, 10'd7);
    n_total++; if (video_on !== 1'b1) $display("FAIL von_x39: got %b exp 1", video_on); else n_pass++;
    wait_xy(10'd40, 10'd7);
    n_total++; if (video_on !== 1'b0) $display("FAIL von_x40: got %b exp 0", video_on); else n_pass++;
  endtask

  task automatic test_blink();
    logic [11:0] exp_rgb;
    logic        exp_ph;
    int c;
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk); rst_n = 1'b1;
    layer_blink_en = 3'b001;
    layer_on = 3'b011;
    bg_rgb = 12'h123;
    for (int f = 0; f < 5; f++) begin
      exp_ph  = ((f / 2) % 2) == 1;
      exp_rgb = exp_ph ? 12'h0F0 : 12'hF00;
      wait_xy(10'd13, 10'd2);
      n_total++; if (rgb !== exp_rgb) $display("FAIL blink_rgb_f%0d: got %h exp %h", f, rgb, exp_rgb); else n_pass++;
      n_total++; if (blink_phase !== exp_ph) $display("FAIL blink_ph_f%0d: got %b exp %b", f, blink_phase, exp_ph); else n_pass++;
      if (f == 1) begin
        c = 0;
        while (frame_start !== 1'b1 && c < 5000) begin c++; @(negedge clk); end
        n_total++; if (frame_start !== 1'b1 || blink_phase !== 1'b0)
          $display("FAIL blink_pre_wrap: fs %b ph %b exp 1/0", frame_start, blink_phase); else n_pass++;
        @(negedge clk);
        n_total++; if (blink_phase !== 1'b1 || pixel_x !== 10'd0 || pixel_y !== 10'd0)
          $display("FAIL blink_post_wrap: ph %b at (%0d,%0d) exp 1 at (0,0)", blink_phase, pixel_x, pixel_y); else n_pass++;
      end
    end
    layer_blink_en = 3'b000;
  endtask

  task automatic test_mid_reset();
    int c;
    layer_on = 3'b001;
    wait_xy(10'd20, 10'd5);
    n_total++; if (rgb !== 12'hF00) $display("FAIL pre_rst_rgb: got %h exp F00", rgb); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (pixel_x !== 10'd0 || pixel_y !== 10'd0)
      $display("FAIL midrst_xy: got (%0d,%0d) exp (0,0)", pixel_x, pixel_y); else n_pass++;
    n_total++; if (hsync !== 1'b1 || vsync !== 1'b1 || rgb !== 12'h000 || blink_phase !== 1'b0)
      $display("FAIL midrst_outs: hs %b vs %b rgb %h ph %b exp 1 1 000 0", hsync, vsync, rgb, blink_phase); else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    c = 0;
    while (hsync === 1'b1 && c < 1000) begin c++; @(negedge clk); end
    n_total++; if (hsync !== 1'b0 || pixel_x !== 10'd47 || pixel_y !== 10'd0)
      $display("FAIL midrst_first_hs: hs %b at (%0d,%0d) exp 0 at (47,0)", hsync, pixel_x, pixel_y); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sync_timing();
    test_priority();
    test_latency();
    test_blink();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
